// File: rtl/calc_pkg.sv
// Shared definitions for the circuit-solver display stages.
//   - state_e       : display FSM state encoding
//   - FP_*          : IEEE-754 single field positions and exponent bias
//   - MV_MAX / MV_W : saturated millivolt limit and its binary width
//   - BCD_W         : width of the 6-digit BCD result
//   - bcd_add3      : double-dabble correction applied before each shift
package calc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StCheck = 3'd1,
        StRead  = 3'd2,
        StConv  = 3'd3,
        StScale = 3'd4,
        StBcd   = 3'd5,
        StShow  = 3'd6
    } state_e;

    localparam int unsigned FP_SIGN   = 31;
    localparam int unsigned FP_EXP_HI = 30;
    localparam int unsigned FP_EXP_LO = 23;
    localparam int unsigned FP_MAN_HI = 22;
    localparam int unsigned FP_MAN_LO = 0;
    localparam int unsigned FP_MAN_W  = 23;
    localparam int          FP_BIAS   = 127;

    localparam logic [7:0] FP_EXP_SPECIAL = 8'hFF;

    localparam int unsigned MV_W  = 20;
    localparam int unsigned BCD_W = 24;

    localparam logic [MV_W-1:0] MV_MAX = 20'd999999;

    // Add 3 to every digit that is 5 or more so the following left shift carries correctly.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one bit per clock.
//   clk            in  system clock
//   program_resetn in  asynchronous active-low reset
//   start          in  1-cycle pulse; samples bin and performs the first shift
//   bin            in  MV_W-bit binary value (at most 999999)
//   done           out high in the cycle whose closing edge writes the last digit
//   bcd            out BCD_W-bit result, digit 0 in the LSB nibble
// The load edge already performs the first of MV_W shifts, so bcd is final in the cycle
// after done, exactly MV_W cycles after the start cycle.
module bin_to_bcd_seq
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             program_resetn,
    input  logic             start,
    input  logic [MV_W-1:0]  bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    logic [MV_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] adj;
    logic             unused_adj_msb;

    assign adj = bcd_add3(bcd_q);
    // The top bit after correction is shifted out; it is always 0 for inputs <= 999999.
    assign unused_adj_msb = adj[BCD_W-1];

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start) begin
            bin_d = bin << 1;
            bcd_d = {{(BCD_W-1){1'b0}}, bin[MV_W-1]};
            cnt_d = 5'(MV_W - 1);
        end else if (cnt_q != 5'd0) begin
            bin_d = bin_q << 1;
            bcd_d = {adj[BCD_W-2:0], bin_q[MV_W-1]};
            cnt_d = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 5'd1);
    assign bcd  = bcd_q;

endmodule

// File: rtl/display_voltage.sv
// Stage 9 of the circuit solver: shows one solved node voltage on the HEX displays.
// Reads a float from the nodeVoltage RAM, converts it to truncated millivolts, then to
// six BCD digits, and re-converts whenever the selected node changes or refresh pulses.
//   clk               in  system clock
//   program_resetn    in  asynchronous active-low reset
//   start_process     in  level, sampled only while idle
//   end_process       out set on the first display update, held until reset
//   node_select       in  node to display
//   refresh           in  1-cycle pulse: re-read the current node
//   numNodes          in  number of valid nodes
//   nodeVoltage_addr  out RAM read address
//   nodeVoltage_data  out RAM write data, tied 0
//   nodeVoltage_wren  out RAM write enable, tied 0
//   nodeVoltage_out   in  RAM read data (IEEE-754 single)
//   bcd_digits        out millivolt magnitude, digit 0 in the LSB nibble, all F = blank
//   sign_neg          out voltage is negative and displays as non-zero
//   overflow          out |V| > 999.999 V, Inf or NaN (digits show 999999)
//   out_of_range      out latched node >= numNodes
//   valid             out display outputs reflect the latched node
module display_voltage
    import calc_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned NODE_W      = 5,
    parameter int unsigned FRAC_BITS   = 16,
    parameter int unsigned DIGITS      = 6
) (
    input  logic                  clk,
    input  logic                  program_resetn,
    input  logic                  start_process,
    output logic                  end_process,
    input  logic [NODE_W-1:0]     node_select,
    input  logic                  refresh,
    input  logic [NODE_W-1:0]     numNodes,
    output logic [NODE_W-1:0]     nodeVoltage_addr,
    output logic [31:0]           nodeVoltage_data,
    output logic                  nodeVoltage_wren,
    input  logic [31:0]           nodeVoltage_out,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic                  sign_neg,
    output logic                  overflow,
    output logic                  out_of_range,
    output logic                  valid
);

    // Left shift that turns the 24-bit significand into a Q(32-FRAC_BITS).FRAC_BITS value.
    localparam logic signed [9:0] SH_OFS  = 10'(int'(FRAC_BITS) - int'(FP_MAN_W));
    localparam logic signed [9:0] EXP_LIM = 10'(32 - int'(FRAC_BITS));
    localparam logic signed [9:0] BIAS_S  = 10'(FP_BIAS);
    // Smallest product whose integer part exceeds MV_MAX.
    localparam logic [41:0] PROD_LIM = (42'(MV_MAX) + 42'd1) << FRAC_BITS;

    state_e              state_q, state_d;
    logic [NODE_W-1:0]   idx_q, idx_d;
    logic [NODE_W-1:0]   addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         mag_q, mag_d;
    logic                ovf_q, ovf_d;
    logic                oor_q, oor_d;
    logic                mv_nz_q, mv_nz_d;

    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                sign_q, sign_d;
    logic                overflow_q, overflow_d;
    logic                out_of_range_q, out_of_range_d;
    logic                valid_q, valid_d;
    logic                end_q, end_d;

    logic                in_range;

    // Float to unsigned fixed-point magnitude, truncating toward zero.
    logic [7:0]          exp_f;
    logic [23:0]         man_f;
    logic signed [9:0]   exp_unb;
    logic signed [9:0]   shamt;
    logic signed [9:0]   rsh;
    logic [31:0]         conv_mag;
    logic                conv_ovf;

    // Millivolt scaling: mag * 1000 as shift-and-subtract, fraction dropped.
    logic [41:0]         mag_ext;
    logic [41:0]         prod;
    logic                mv_big;
    logic [MV_W-1:0]     mv_raw;
    logic [MV_W-1:0]     mv_sat;

    logic                bcd_start;
    logic                bcd_done;
    logic [BCD_W-1:0]    bcd_out;

    assign in_range = (idx_q < numNodes);

    assign exp_f   = data_q[FP_EXP_HI:FP_EXP_LO];
    assign man_f   = {1'b1, data_q[FP_MAN_HI:FP_MAN_LO]};
    assign exp_unb = $signed({2'b00, exp_f}) - BIAS_S;
    assign shamt   = exp_unb + SH_OFS;
    assign rsh     = -shamt;

    always_comb begin
        conv_mag = '0;
        conv_ovf = 1'b0;
        if (exp_f == 8'd0) begin
            // Zero and denormals are far below 1 mV.
            conv_mag = '0;
        end else if ((exp_f == FP_EXP_SPECIAL) || (exp_unb >= EXP_LIM)) begin
            conv_ovf = 1'b1;
        end else if (shamt >= 10'sd0) begin
            conv_mag = {8'd0, man_f} << shamt[3:0];
        end else if (rsh < 10'sd24) begin
            conv_mag = {8'd0, man_f} >> rsh[4:0];
        end
    end

    assign mag_ext = {10'd0, mag_q};
    assign prod    = (mag_ext << 10) - (mag_ext << 4) - (mag_ext << 3);
    assign mv_big  = (prod >= PROD_LIM);
    assign mv_raw  = prod[FRAC_BITS +: MV_W];
    assign mv_sat  = (mv_big || ovf_q) ? MV_MAX : mv_raw;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        data_d         = data_q;
        mag_d          = mag_q;
        ovf_d          = ovf_q;
        oor_d          = oor_q;
        mv_nz_d        = mv_nz_q;
        digits_d       = digits_q;
        sign_d         = sign_q;
        overflow_d     = overflow_q;
        out_of_range_d = out_of_range_q;
        valid_d        = valid_q;
        end_d          = end_q;
        bcd_start      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_process) begin
                    idx_d   = node_select;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!in_range) begin
                    oor_d   = 1'b1;
                    state_d = StShow;
                end else begin
                    oor_d   = 1'b0;
                    addr_d  = idx_q;
                    cnt_d   = 4'(RAM_LATENCY - 1);
                    state_d = StRead;
                end
            end
            StRead: begin
                if (cnt_q == 4'd0) begin
                    data_d  = nodeVoltage_out;
                    state_d = StConv;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StConv: begin
                mag_d   = conv_mag;
                ovf_d   = conv_ovf;
                state_d = StScale;
            end
            StScale: begin
                bcd_start = 1'b1;
                ovf_d     = ovf_q | mv_big;
                mv_nz_d   = (mv_sat != '0);
                state_d   = StBcd;
            end
            StBcd: begin
                if (bcd_done) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                if (!valid_q) begin
                    // First SHOW cycle: the converter result is final, publish it.
                    if (oor_q) begin
                        digits_d       = '1;
                        sign_d         = 1'b0;
                        overflow_d     = 1'b0;
                        out_of_range_d = 1'b1;
                    end else begin
                        digits_d       = bcd_out;
                        sign_d         = data_q[FP_SIGN] & mv_nz_q;
                        overflow_d     = ovf_q;
                        out_of_range_d = 1'b0;
                    end
                    valid_d = 1'b1;
                    end_d   = 1'b1;
                end else if ((node_select != idx_q) || refresh) begin
                    valid_d = 1'b0;
                    idx_d   = node_select;
                    state_d = StCheck;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            data_q         <= '0;
            mag_q          <= '0;
            ovf_q          <= 1'b0;
            oor_q          <= 1'b0;
            mv_nz_q        <= 1'b0;
            digits_q       <= '0;
            sign_q         <= 1'b0;
            overflow_q     <= 1'b0;
            out_of_range_q <= 1'b0;
            valid_q        <= 1'b0;
            end_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            data_q         <= data_d;
            mag_q          <= mag_d;
            ovf_q          <= ovf_d;
            oor_q          <= oor_d;
            mv_nz_q        <= mv_nz_d;
            digits_q       <= digits_d;
            sign_q         <= sign_d;
            overflow_q     <= overflow_d;
            out_of_range_q <= out_of_range_d;
            valid_q        <= valid_d;
            end_q          <= end_d;
        end
    end

    bin_to_bcd_seq u_bcd (
        .clk            (clk),
        .program_resetn (program_resetn),
        .start          (bcd_start),
        .bin            (mv_sat),
        .done           (bcd_done),
        .bcd            (bcd_out)
    );

    // The address is presented during CHECK so the registered RAM has its full latency
    // before READ captures; an out-of-range node leaves the address untouched.
    assign nodeVoltage_addr = ((state_q == StCheck) && in_range) ? idx_q : addr_q;
    assign nodeVoltage_data = '0;
    assign nodeVoltage_wren = 1'b0;

    assign bcd_digits   = digits_q;
    assign sign_neg     = sign_q;
    assign overflow     = overflow_q;
    assign out_of_range = out_of_range_q;
    assign valid        = valid_q;
    assign end_process  = end_q;

endmodule

// File: tb/tb_display_voltage.sv
module tb_display_voltage;

    logic        clk;
    logic        program_resetn;
    logic        start_process;
    logic        end_process;
    logic [4:0]  node_select;
    logic        refresh;
    logic [4:0]  numNodes;
    logic [4:0]  nodeVoltage_addr;
    logic [31:0] nodeVoltage_data;
    logic        nodeVoltage_wren;
    logic [31:0] nodeVoltage_out;
    logic [23:0] bcd_digits;
    logic        sign_neg;
    logic        overflow;
    logic        out_of_range;
    logic        valid;

    display_voltage dut (
        .clk              (clk),
        .program_resetn   (program_resetn),
        .start_process    (start_process),
        .end_process      (end_process),
        .node_select      (node_select),
        .refresh          (refresh),
        .numNodes         (numNodes),
        .nodeVoltage_addr (nodeVoltage_addr),
        .nodeVoltage_data (nodeVoltage_data),
        .nodeVoltage_wren (nodeVoltage_wren),
        .nodeVoltage_out  (nodeVoltage_out),
        .bcd_digits       (bcd_digits),
        .sign_neg         (sign_neg),
        .overflow         (overflow),
        .out_of_range     (out_of_range),
        .valid            (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage registered RAM: data for an address appears two clocks later.
    logic [31:0] mem [0:31];
    logic [31:0] ram_r1, ram_r2;
    always @(posedge clk) begin
        ram_r1 <= mem[nodeVoltage_addr];
        ram_r2 <= ram_r1;
    end
    assign nodeVoltage_out = ram_r2;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact value of the float, truncated to 1/65536, times 1000, truncated.
    task automatic ref_conv(input logic [31:0] w, output logic [23:0] dig,
                            output logic neg, output logic ovf);
        int   e;
        real  v;
        real  fx;
        int   mv;
        e   = int'(w[30:23]);
        ovf = 1'b0;
        mv  = 0;
        if (e == 255) begin
            ovf = 1'b1;
        end else begin
            if (e == 0) begin
                v = 0.0;
            end else begin
                v = real'({1'b1, w[22:0]});
                if (e > 150) repeat (e - 150) v = v * 2.0;
                else repeat (150 - e) v = v / 2.0;
            end
            if (v >= 65536.0) begin
                ovf = 1'b1;
            end else begin
                fx = $floor(v * 65536.0);
                mv = $rtoi($floor(fx * 1000.0 / 65536.0));
                if (mv > 999999) ovf = 1'b1;
            end
        end
        if (ovf) mv = 999999;
        neg = w[31] && (mv != 0);
        for (int i = 0; i < 6; i++) begin
            dig[4*i +: 4] = 4'(mv % 10);
            mv = mv / 10;
        end
    endtask

    // Call with the trigger inputs already set; the first edge is the trigger edge.
    task automatic run_trigger(input bit chk_drop, input int pulse_at, output int lat,
                               output int addr_moves);
        logic [4:0] addr0;
        addr0 = nodeVoltage_addr;
        addr_moves = 0;
        step();
        start_process = 1'b0;
        refresh = 1'b0;
        if (chk_drop) check("valid drop after trigger", 32'(valid), 32'd0);
        lat = 0;
        while (valid !== 1'b1 && lat < 60) begin
            refresh = (lat == pulse_at) ? 1'b1 : 1'b0;
            step();
            lat++;
            if (nodeVoltage_addr !== addr0) addr_moves++;
        end
        refresh = 1'b0;
        if (valid !== 1'b1) lat = -1;
    endtask

    task automatic do_show(input string tag, input bit chk_drop, input int pulse_at,
                           input int exp_lat, input logic [23:0] ed, input logic en,
                           input logic eo, input logic eoor);
        int lat;
        int moves;
        run_trigger(chk_drop, pulse_at, lat, moves);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " digits"}, {8'd0, bcd_digits}, {8'd0, ed});
        check({tag, " sign/ovf/oor"}, {29'd0, sign_neg, overflow, out_of_range},
              {29'd0, en, eo, eoor});
        check({tag, " end_process"}, 32'(end_process), 32'd1);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [23:0] digits;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [23:0] ed;
        logic        en, eo;
        logic [31:0] rnd;
        logic [31:0] w;
        logic [7:0]  e;
        int          lat, moves, k;

        vecs[0]  = '{32'hBF9E0419, 24'h001234, 1'b1, 1'b0};  // -1.2345, truncated
        vecs[1]  = '{32'h80000000, 24'h000000, 1'b0, 1'b0};  // -0.0
        vecs[2]  = '{32'h447A0000, 24'h999999, 1'b0, 1'b1};  // 1000.0
        vecs[3]  = '{32'h7FC00000, 24'h999999, 1'b0, 1'b1};  // NaN
        vecs[4]  = '{32'hFF800000, 24'h999999, 1'b1, 1'b1};  // -Inf
        vecs[5]  = '{32'h00000001, 24'h000000, 1'b0, 1'b0};  // denormal
        vecs[6]  = '{32'hBA000000, 24'h000000, 1'b0, 1'b0};  // -0.000488, sub-mV
        vecs[7]  = '{32'h3A83126F, 24'h000000, 1'b0, 1'b0};  // 0.001 truncates to 0
        vecs[8]  = '{32'h4479C000, 24'h999000, 1'b0, 1'b0};  // 999.0
        vecs[9]  = '{32'h477FFF00, 24'h999999, 1'b0, 1'b1};  // 65535.0
        vecs[10] = '{32'h47800000, 24'h999999, 1'b0, 1'b1};  // 65536.0
        vecs[11] = '{32'h3F000000, 24'h000500, 1'b0, 1'b0};  // 0.5

        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        program_resetn = 1'b0;
        start_process  = 1'b0;
        refresh        = 1'b0;
        node_select    = 5'd0;
        numNodes       = 5'd0;
        step();
        step();
        check("reset valid/end/sign/ovf/oor",
              {27'd0, valid, end_process, sign_neg, overflow, out_of_range}, 32'd0);
        check("reset digits", {8'd0, bcd_digits}, 32'd0);
        check("reset addr", {27'd0, nodeVoltage_addr}, 32'd0);
        check("ram data/wren tied", nodeVoltage_data | {31'd0, nodeVoltage_wren}, 32'd0);
        program_resetn = 1'b1;
        repeat (4) step();
        check("idle without start", 32'(valid), 32'd0);

        // Basic conversion from idle.
        mem[3] = 32'h40A00000;
        mem[1] = 32'h3F800000;
        mem[4] = 32'h3F800000;
        numNodes = 5'd4;
        node_select = 5'd3;
        start_process = 1'b1;
        do_show("5.0", 1'b0, -1, 25, 24'h005000, 1'b0, 1'b0, 1'b0);
        check("addr after read", {27'd0, nodeVoltage_addr}, 32'd3);

        // Table of single values, each re-read through refresh.
        for (int i = 0; i < 12; i++) begin
            mem[3] = vecs[i].word;
            refresh = 1'b1;
            do_show($sformatf("vec%0d", i), 1'b1, -1, 25, vecs[i].digits, vecs[i].neg,
                    vecs[i].ovf, 1'b0);
        end

        // Out-of-range node: blank digits after two cycles, RAM address unchanged.
        numNodes = 5'd5;
        node_select = 5'd7;
        run_trigger(1'b1, -1, lat, moves);
        check("oor latency", 32'(lat), 32'd2);
        check("oor digits", {8'd0, bcd_digits}, 32'h00FFFFFF);
        check("oor flags", {29'd0, sign_neg, overflow, out_of_range}, 32'd1);
        check("oor addr unchanged", 32'(moves), 32'd0);

        // Boundary: numNodes-1 is in range, numNodes is not.
        node_select = 5'd4;
        do_show("node numNodes-1", 1'b1, -1, 25, 24'h001000, 1'b0, 1'b0, 1'b0);
        node_select = 5'd5;
        do_show("node numNodes", 1'b1, -1, 2, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);

        // Switch change 3 -> 1, with a refresh pulse during BCD that must be ignored.
        mem[3] = 32'h40A00000;
        node_select = 5'd3;
        do_show("back to 3", 1'b1, -1, 25, 24'h005000, 1'b0, 1'b0, 1'b0);
        node_select = 5'd1;
        do_show("switch 3->1 refresh mid-BCD", 1'b1, 12, 25, 24'h001000, 1'b0, 1'b0, 1'b0);

        // Randomised values against the reference model.
        numNodes = 5'd4;
        for (int it = 0; it < 30; it++) begin
            k = int'($urandom_range(0, 3));
            rnd = $urandom;
            case ($urandom_range(0, 7))
                0:       e = 8'hFF;
                1:       e = 8'h00;
                default: e = 8'($urandom_range(110, 145));
            endcase
            w = {rnd[31], e, rnd[22:0]};
            mem[k] = w;
            ref_conv(w, ed, en, eo);
            if (5'(k) != node_select) node_select = 5'(k);
            else refresh = 1'b1;
            do_show($sformatf("rand%0d %h", it, w), 1'b1, -1, 25, ed, en, eo, 1'b0);
        end

        // Reset in the middle of BCD clears everything at once; restart needs start_process.
        mem[3] = 32'h40A00000;
        node_select = 5'd3;
        refresh = 1'b1;
        do_show("pre-reset", 1'b1, -1, 25, 24'h005000, 1'b0, 1'b0, 1'b0);
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        repeat (12) step();
        program_resetn = 1'b0;
        #1;
        check("async reset flags",
              {27'd0, valid, end_process, sign_neg, overflow, out_of_range}, 32'd0);
        check("async reset digits", {8'd0, bcd_digits}, 32'd0);
        check("async reset addr", {27'd0, nodeVoltage_addr}, 32'd0);
        step();
        step();
        program_resetn = 1'b1;
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        repeat (30) step();
        check("idle after reset", {30'd0, valid, end_process}, 32'd0);
        start_process = 1'b1;
        do_show("restart", 1'b0, -1, 25, 24'h005000, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
